upcounter_4bit: RTL and testbench

UPCOUNTER_4BIT -- requirements
Module: upcounter_4bit

---
 rtl/upcounter_4bit.sv | 34 +++
 tb/tb_upcounter_4bit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/upcounter_4bit.sv
// upcounter_4bit: free-running modulo-2^WIDTH up counter.
// Ports: Clk (clock), RST (async active-low reset), OUT (count).
module upcounter_4bit #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             Clk,
    input  logic             RST,
    output logic [WIDTH-1:0] OUT
);

    // Reset value is truncated to the counter width.
    localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Plain binary add wraps naturally at 2^WIDTH.
    always_comb begin
        count_d = count_q + One;
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            count_q <= RstVal;
        end else begin
            count_q <= count_d;
        end
    end

    assign OUT = count_q;

endmodule

// File: tb/tb_upcounter_4bit.sv
// tb_upcounter_4bit: vector table, corner sequences and random
// reset activity against an edge-counting reference model.
module tb_upcounter_4bit;

    logic       Clk = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] OUT;
    bit         clk_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int since    = 0;

    typedef struct {
        logic       rst;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[10];

    upcounter_4bit #(
        .WIDTH      (4),
        .RESET_VALUE(0)
    ) dut (
        .Clk(Clk),
        .RST(RST),
        .OUT(OUT)
    );

    always #5 if (clk_en) Clk = ~Clk;

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        logic [3:0] prev;
        logic       r;

        vecs[0] = '{1'b0, 4'h0};
        vecs[1] = '{1'b1, 4'h1};
        vecs[2] = '{1'b1, 4'h2};
        vecs[3] = '{1'b1, 4'h3};
        vecs[4] = '{1'b1, 4'h4};
        vecs[5] = '{1'b1, 4'h5};
        vecs[6] = '{1'b0, 4'h0};
        vecs[7] = '{1'b0, 4'h0};
        vecs[8] = '{1'b1, 4'h1};
        vecs[9] = '{1'b1, 4'h2};

        // reset hold across several edges of both polarities
        repeat (4) begin
            @(posedge Clk); #1;
            check("rst_hold_pos", OUT, 4'h0);
            @(negedge Clk); #1;
            check("rst_hold_neg", OUT, 4'h0);
        end

        // table: apply between edges, check after rising edge;
        // falling edge must leave the previous value
        prev = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk); #1;
            check("vec_fall_hold", OUT, prev);
            RST = vecs[i].rst;
            @(posedge Clk); #1;
            check($sformatf("vec%0d", i), OUT, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // wrap: 15 -> 0 -> 1
        @(negedge Clk);
        RST = 1'b0;
        #1 check("wrap_rst", OUT, 4'h0);
        RST = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge Clk); #1;
            check($sformatf("wrap_e%0d", e), OUT, 4'(e % 16));
        end

        // run up to 9, then async reset between edges
        repeat (8) @(posedge Clk);
        #1 check("pre_async", OUT, 4'h9);
        @(negedge Clk); #1;
        RST = 1'b0;
        #1 check("async_now", OUT, 4'h0);
        repeat (2) begin
            @(posedge Clk); #1;
            check("async_hold", OUT, 4'h0);
        end

        // clock stopped with counter running
        @(negedge Clk);
        RST = 1'b1;
        repeat (3) @(posedge Clk);
        #1 check("pre_stop", OUT, 4'h3);
        clk_en = 1'b0;
        #100 check("clk_stopped", OUT, 4'h3);
        clk_en = 1'b1;
        @(posedge Clk); #1;
        check("clk_resume", OUT, 4'h4);

        // release coincident with a rising edge: the flop sees the
        // pre-edge reset level, so counting starts one edge later
        @(negedge Clk);
        RST = 1'b0;
        @(posedge Clk);
        RST <= 1'b1;
        #1 check("coinc_edge", OUT, 4'h0);
        @(posedge Clk); #1;
        check("coinc_next", OUT, 4'h1);

        // random reset activity vs edge-count model
        since = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge Clk); #1;
            r = ($urandom_range(0, 7) != 0);
            RST = r;
            if (!r) begin
                since = 0;
                #1 check("rand_async", OUT, 4'h0);
            end
            @(posedge Clk); #1;
            if (r) since++;
            check("rand", OUT, 4'(since % 16));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
